// File: rtl/selfadd_rr_sched.sv
// selfadd_rr_sched: round-robin scheduler sharing one self-add accumulator among NREQ requesters,
// forwarding one BEATS-beat burst at a time and returning the result to the burst owner.
module selfadd_rr_sched #(
    parameter int NREQ      = 4,
    parameter int BEATS     = 3,
    parameter int DRAIN_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_v,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      beat_rdy,
    input  logic                 halt,
    output logic                 acc_data_v,
    output logic [15:0]          acc_a,
    output logic [15:0]          acc_b,
    output logic                 acc_usr_rst,
    output logic                 acc_halt,
    input  logic                 acc_out_v,
    input  logic [15:0]          acc_out_a,
    input  logic [15:0]          acc_out_b,
    output logic [NREQ-1:0]      res_v,
    output logic [15:0]          res_a,
    output logic [15:0]          res_b,
    output logic                 busy,
    output logic                 err
);
    localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BEATS + 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
    state_t state, state_nx;
    logic [GW-1:0] ptr, gnt, pick, off;
    logic [GW:0] sum;
    logic [NREQ-1:0] rot;
    logic [BW-1:0] beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic [15:0] a_arr [NREQ];
    logic [15:0] b_arr [NREQ];
    logic accept, last_beat, timeout, start;
    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign a_arr[g] = req_a[16*g +: 16];
        assign b_arr[g] = req_b[16*g +: 16];
    end
    // rotate requests so bit 0 is the current pointer; lowest set bit is the winner
    always_comb begin
        rot = NREQ'({req_v, req_v} >> ptr);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = GW'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        pick = GW'(sum >= (GW+1)'(NREQ) ? sum - (GW+1)'(NREQ) : sum);
    end
    assign accept    = state == ISSUE && req_v[gnt] && !halt;
    assign last_beat = accept && beat_cnt == BW'(BEATS - 1);
    assign timeout   = !halt && drain_cnt == DW'(DRAIN_MAX - 1);
    assign start     = state == IDLE && state_nx == ISSUE;
    assign beat_rdy  = accept ? NREQ'(1) << gnt : '0;
    assign res_v     = state == RESP ? NREQ'(1) << gnt : '0;
    assign busy      = state != IDLE;
    assign acc_halt  = halt;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (|req_v && !halt) ? ISSUE : IDLE;
            ISSUE:   state_nx = last_beat ? DRAIN : ISSUE;
            DRAIN:   state_nx = (acc_out_v || timeout) ? RESP : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            acc_data_v  <= 1'b0;
            acc_a       <= '0;
            acc_b       <= '0;
            acc_usr_rst <= 1'b0;
            res_a       <= '0;
            res_b       <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            acc_usr_rst <= start;
            acc_data_v  <= accept;
            if (start) gnt <= pick;
            if (accept) begin
                acc_a    <= a_arr[gnt];
                acc_b    <= b_arr[gnt];
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (last_beat) drain_cnt <= '0;
            // a result is taken even under halt; only the timeout count freezes
            if (state == DRAIN) begin
                if (acc_out_v) begin
                    res_a <= acc_out_a;
                    res_b <= acc_out_b;
                end else if (!halt) begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (timeout) begin
                        err   <= 1'b1;
                        res_a <= '0;
                        res_b <= '0;
                    end
                end
            end
            if (state == RESP) ptr <= gnt == GW'(NREQ - 1) ? '0 : gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_selfadd_rr_sched.sv
// tb_selfadd_rr_sched: requester agents and an accumulator-unit model drive the scheduler;
// a transaction-level round-robin model predicts grants, beats and results.
module tb_selfadd_rr_sched;
    localparam int NREQ = 4, BEATS = 3, DRAIN_MAX = 15;
    logic clk = 0, rst = 1, halt = 0, acc_out_v = 0;
    logic [NREQ-1:0] req_v = '0, beat_rdy, res_v;
    logic [16*NREQ-1:0] req_a = '0, req_b = '0;
    logic acc_data_v, acc_usr_rst, acc_halt, busy, err;
    logic [15:0] acc_a, acc_b, res_a, res_b, acc_out_a = '0, acc_out_b = '0;
    int checks = 0, failures = 0;

    selfadd_rr_sched #(.NREQ(NREQ), .BEATS(BEATS), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .rst(rst), .req_v(req_v), .req_a(req_a), .req_b(req_b), .beat_rdy(beat_rdy),
        .halt(halt), .acc_data_v(acc_data_v), .acc_a(acc_a), .acc_b(acc_b),
        .acc_usr_rst(acc_usr_rst), .acc_halt(acc_halt), .acc_out_v(acc_out_v),
        .acc_out_a(acc_out_a), .acc_out_b(acc_out_b), .res_v(res_v), .res_a(res_a),
        .res_b(res_b), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // requester agents and scheduler reference state
    int pend [NREQ];
    int bi [NREQ];
    logic [15:0] da [NREQ];
    logic [15:0] db [NREQ];
    int owner = -1, ptr_m = 0, n_bursts = 0, n_done = 0, n_res = 0, n_usr = 0;
    logic [15:0] sa = '0, sb = '0, exp_a = '0, exp_b = '0;
    bit res_due = 0, exp_dv = 0, err_exp = 0, idle_due = 0;
    int glog [$];
    // accumulator unit model
    logic [15:0] ua = '0, ub = '0;
    int ucnt = 0, lat = 0, since_last = 0;
    bit armed = 0;
    // stimulus knobs
    bit dead = 0, fixed = 0, drop_en = 0;
    int halt_pct = 0, force_halt = 0, fixed_lat = -1, drop_force = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_data(input int i);
        da[i] = fixed ? 16'(2 * bi[i] + 1) : 16'($urandom);
        db[i] = fixed ? 16'(2 * bi[i] + 2) : 16'($urandom);
    endtask

    function automatic int rr_expect();
        for (int k = 0; k < NREQ; k++)
            if (pend[(ptr_m + k) % NREQ] > 0) return (ptr_m + k) % NREQ;
        return -1;
    endfunction

    task automatic accept(input int i);
        if (bi[i] == 0) begin
            check("grant", i, rr_expect());
            check("grant_after_resp", res_due, 0);
            owner = i;
            sa = '0;
            sb = '0;
            glog.push_back(i);
            n_bursts++;
        end else check("grant_held", i, owner);
        sa += da[i];
        sb += db[i];
        exp_dv = 1;
        exp_a = da[i];
        exp_b = db[i];
        bi[i]++;
        if (bi[i] == BEATS) begin
            bi[i] = 0;
            pend[i]--;
            res_due = 1;
            n_done++;
        end
        new_data(i);
    endtask

    task automatic step(input bit do_rst);
        bit dropi;
        @(negedge clk);
        since_last++;
        check("acc_data_v", acc_data_v, exp_dv);
        if (exp_dv) begin
            check("acc_a", acc_a, exp_a);
            check("acc_b", acc_b, exp_b);
        end
        exp_dv = 0;
        if (idle_due) check("idle_after_resp", busy, 0);
        idle_due = 0;
        if (res_v != 0) begin
            check("res_due", res_due, 1);
            check("res_owner", res_v, owner < 0 ? 0 : 32'(1) << owner);
            check("res_a", res_a, dead ? 16'h0 : sa);
            check("res_b", res_b, dead ? 16'h0 : sb);
            if (dead) begin
                check("drain_timeout_len", since_last, DRAIN_MAX);
                err_exp = 1;
            end
            ptr_m = (owner + 1) % NREQ;
            res_due = 0;
            idle_due = 1;
            n_res++;
        end
        check("err", err, err_exp);
        if (acc_usr_rst) begin
            ua = '0;
            ub = '0;
            ucnt = 0;
            n_usr++;
        end
        if (acc_data_v) begin
            ua += acc_a;
            ub += acc_b;
            ucnt++;
            if (ucnt == BEATS) begin
                ucnt = 0;
                since_last = 0;
                armed = !dead;
                lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 4));
            end
        end
        rst = do_rst;
        halt = force_halt > 0 || $urandom_range(0, 99) < halt_pct;
        if (force_halt > 0) force_halt--;
        if (armed && lat == 0) begin
            acc_out_v = 1;
            acc_out_a = ua;
            acc_out_b = ub;
            armed = 0;
        end else begin
            if (armed) lat--;
            // stray results while no burst is draining must be ignored
            acc_out_v = !armed && !res_due && $urandom_range(0, 7) == 0;
            acc_out_a = 16'($urandom);
            acc_out_b = 16'($urandom);
        end
        for (int i = 0; i < NREQ; i++) begin
            dropi = 0;
            if (i == owner && bi[i] > 0) begin
                if (drop_force > 0 && bi[i] == 1) begin
                    dropi = 1;
                    drop_force--;
                end else if (drop_en && $urandom_range(0, 3) == 0) dropi = 1;
            end
            req_v[i] = pend[i] > 0 && !dropi;
            req_a[16*i +: 16] = da[i];
            req_b[16*i +: 16] = db[i];
        end
        #1;
        if (do_rst) begin
            check("rst_ctl", {acc_data_v, acc_usr_rst, busy, err, res_v, beat_rdy}, 0);
            check("rst_acc", {acc_a, acc_b}, 0);
            check("rst_res", {res_a, res_b}, 0);
            ptr_m = 0;
            owner = -1;
            res_due = 0;
            err_exp = 0;
            armed = 0;
            ucnt = 0;
            ua = '0;
            ub = '0;
            for (int i = 0; i < NREQ; i++) bi[i] = 0;
            return;
        end
        check("acc_halt", acc_halt, halt);
        check("rdy_without_req", beat_rdy & ~req_v, 0);
        if (halt) check("rdy_in_halt", beat_rdy, 0);
        if (owner >= 0 && bi[owner] > 0 && req_v[owner] && !halt)
            check("rdy_mid_burst", beat_rdy[owner], 1);
        if (beat_rdy != 0) begin
            check("rdy_onehot", $onehot(beat_rdy), 1);
            for (int i = 0; i < NREQ; i++) if (beat_rdy[i]) accept(i);
        end
    endtask

    function automatic bit active();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += pend[i];
        return s > 0 || res_due || busy;
    endfunction

    task automatic drain(input int bound);
        int n = 0;
        while (active() && n < bound) begin
            step(0);
            n++;
        end
        check("drain_bound", n < bound, 1);
    endtask

    initial begin
        int n;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0;
            bi[i] = 0;
            new_data(i);
        end
        step(1);
        step(1);
        step(0);
        // single requester with known beats
        fixed = 1;
        pend[1] = 1;
        new_data(1);
        drain(100);
        check("t1_res_a", res_a, 16'd9);
        check("t1_res_b", res_b, 16'd12);
        fixed = 0;
        new_data(1);
        // all requesters from reset
        step(1);
        glog.delete();
        pend = '{2, 1, 1, 1};
        drain(300);
        check("t2_grants", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++) check("t2_order", glog[k], exp_order[k]);
        // mid-burst drop of requester 2
        pend[2] = 1;
        drop_force = 2;
        drain(100);
        // halt during issue and during drain
        pend[3] = 1;
        fixed_lat = 2;
        n = 0;
        while (bi[3] != 1 && n < 50) begin step(0); n++; end
        check("t4_wait_beat", n < 50, 1);
        force_halt = 4;
        n = 0;
        while (!res_due && n < 50) begin step(0); n++; end
        check("t4_wait_last", n < 50, 1);
        force_halt = 4;
        drain(100);
        fixed_lat = -1;
        // unit never answers, then err stays set
        dead = 1;
        pend[0] = 1;
        drain(100);
        dead = 0;
        pend[1] = 1;
        drain(100);
        check("t5_err_sticky", err, 1);
        // reset on the second beat
        pend[3] = 1;
        pend[1] = 1;
        n = 0;
        while (!(owner >= 0 && bi[owner] == 1) && n < 50) begin step(0); n++; end
        check("t6_wait_beat", n < 50, 1);
        check("t6_owner", owner, 3);
        step(1);
        drain(200);
        // randomized traffic
        halt_pct = 10;
        drop_en = 1;
        repeat (40) begin
            for (int i = 0; i < NREQ; i++) pend[i] = $urandom_range(0, 2);
            drain(400);
        end
        halt_pct = 0;
        drop_en = 0;
        step(0);
        check("usr_rst_count", n_usr, n_bursts);
        check("res_count", n_res, n_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
